// File: rtl/regfile_multiport_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_multiport_sb_if
//
// Purpose: bundles the write-back, issue and read-port signals of the
// multiport register file with its busy-bit scoreboard.
//
// Parameters:
//   DATA_W   register width in bits
//   NUM_REGS register count (power of 2, >= 2)
//   NUM_RD   number of read ports (1..4)
//
// Signals:
//   wr_en / wr_addr / wr_data   write-back port (WB stage)
//   iss_en / iss_addr           issue port, marks destination busy (ID stage)
//   rd_addr                     packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   rd_data                     packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy                     per-port "write pending" flag
//   busy_cnt                    number of busy registers
//
// Modports:
//   master - pipeline side (drives wr/iss/rd_addr)
//   slave  - register file side
// -----------------------------------------------------------------------------
interface regfile_multiport_sb_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       iss_en;
  logic [ADDR_W-1:0]          iss_addr;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic [ADDR_W:0]            busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data,
    output iss_en, iss_addr,
    output rd_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  iss_en, iss_addr,
    input  rd_addr,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_multiport_sb.sv
// -----------------------------------------------------------------------------
// regfile_multiport_sb
//
// Purpose: general-purpose register file for the pipelined core with
// NUM_RD combinational read ports, one clocked write port, write-to-read
// bypass and a per-register busy scoreboard used by hazard detection.
//
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RST_N  asynchronous active-low reset (clears registers, busy bits, count)
//   bus    regfile_multiport_sb_if.slave:
//            wr_en/wr_addr/wr_data  write-back (1-cycle write latency)
//            iss_en/iss_addr        mark destination busy at the next edge
//            rd_addr -> rd_data     combinational reads with bypass
//            rd_busy                busy bit of each read port's register,
//                                   masked by a same-cycle write-back
//            busy_cnt               registered popcount of the busy vector
//
// Optional feature (macro REGFILE_ZERO_REG_EN):
//   When defined, register 0 is hard-wired to zero: writes to it are dropped
//   (and never bypass) and issue to it never sets busy.
// -----------------------------------------------------------------------------
module regfile_multiport_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  regfile_multiport_sb_if.slave   bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = ADDR_W + 1;

  // ---------------------------------------------------------------------------
  // Effective write / issue enables. With the zero register enabled, any
  // access to index 0 is squashed here so every downstream path (storage,
  // bypass, scoreboard, counter) sees it as if it never happened.
  // ---------------------------------------------------------------------------
  logic wr_eff;
  logic iss_eff;

  always_comb begin
    wr_eff  = bus.wr_en;
    iss_eff = bus.iss_en;
`ifdef REGFILE_ZERO_REG_EN
    if (bus.wr_addr == '0) begin
      wr_eff = 1'b0;
    end
    if (bus.iss_addr == '0) begin
      iss_eff = 1'b0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (wr_eff) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
`ifdef REGFILE_ZERO_REG_EN
    regs_d[0] = '0;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Set has priority over clear on the same index: the
  // issuing instruction is a newer producer than the one retiring.
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_eff) begin
      set_vec[bus.iss_addr] = 1'b1;
    end
    if (wr_eff) begin
      clr_vec[bus.wr_addr] = 1'b1;
    end
    busy_d = set_vec | (busy_q & ~clr_vec);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy counter, maintained incrementally rather than by a full popcount.
  // With one set and one clear port, the busy vector can gain at most one bit
  // and lose at most one bit per edge:
  //   inc: issue to a register that is not yet busy
  //   dec: write-back to a busy register that is not simultaneously re-issued
  // Both together cancel. Because inc/dec mirror exactly the bit changes of
  // busy_q, the count stays in 0..NUM_REGS and cannot wrap.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] busy_cnt_q;
  logic [CNT_W-1:0] busy_cnt_d;
  logic             cnt_inc;
  logic             cnt_dec;

  always_comb begin
    cnt_inc    = iss_eff && !busy_q[bus.iss_addr];
    cnt_dec    = wr_eff && busy_q[bus.wr_addr] &&
                 !(iss_eff && (bus.iss_addr == bus.wr_addr));
    busy_cnt_d = busy_cnt_q;
    if (cnt_inc && !cnt_dec) begin
      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    end else if (!cnt_inc && cnt_dec) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  // ---------------------------------------------------------------------------
  // Read ports. Each port compares against the write-back index on its own,
  // so any number of ports may bypass the same write in the same cycle.
  // A bypassed read also reports not-busy, matching the data it returns.
  // Issue in the current cycle is deliberately invisible until the next edge.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]        rd_idx  [NUM_RD];
  logic [DATA_W-1:0]        rd_val  [NUM_RD];
  logic [NUM_RD-1:0]        rd_hit;
  logic [NUM_RD-1:0]        rd_busy_w;
  logic [NUM_RD*DATA_W-1:0] rd_data_w;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    assign rd_idx[gi]    = bus.rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_hit[gi]    = wr_eff && (bus.wr_addr == rd_idx[gi]);
    assign rd_val[gi]    = rd_hit[gi] ? bus.wr_data : regs_q[rd_idx[gi]];
    assign rd_busy_w[gi] = busy_q[rd_idx[gi]] && !rd_hit[gi];
  end

  always_comb begin
    rd_data_w = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_w[k*DATA_W +: DATA_W] = rd_val[k];
    end
  end

  assign bus.rd_data = rd_data_w;
  assign bus.rd_busy = rd_busy_w;

endmodule
